calc2_req_agent: RTL

- Synthesizable initiator for one calc2 request port.
- Accepts (cmd, op1, op2) transactions on a valid/ready interface and allocates a free 2-bit tag.
- Drives the calc2 two-cycle request protocol: cmd, tag and op1 in the first cycle; op2 in the second.
- Collects out_resp/out_data/out_tag from the same port, matches them by tag, and returns completed results upstream. Four instances sit between a traffic source and calc2_top ports 1–4.

---
 rtl/calc2_req_agent.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/calc2_req_agent.sv
// calc2 request-port initiator: tag allocation, two-cycle issue, tag-matched response return.
// Optional per-tag response timeout is enabled with `define CALC2_REQ_TIMEOUT_EN.

module calc2_req_slot #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       c_clk,
  input  logic       reset,
  input  logic       alloc,
  input  logic       free,
  input  logic [3:0] cmd_in,
  output logic       busy,
  output logic [3:0] cmd,
  output logic       expired
);
  always_ff @(posedge c_clk) begin
    if (reset) begin
      busy <= 1'b0;
      cmd  <= '0;
    end else if (alloc) begin
      busy <= 1'b1;
      cmd  <= cmd_in;
    end else if (free) begin
      busy <= 1'b0;
    end
  end

`ifdef CALC2_REQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] cnt;

  // Saturates at the limit so a deferred expiry stays pending until it is taken.
  always_ff @(posedge c_clk) begin
    if (reset || alloc)         cnt <= '0;
    else if (busy && !expired)  cnt <= cnt + TO_W'(1);
  end

  assign expired = busy && (cnt == TO_W'(TIMEOUT_CYCLES));
`else
  assign expired = 1'b0;
`endif
endmodule

module calc2_req_agent #(
  parameter int DATA_W         = 32,
  parameter int MAX_OUT        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic              txn_valid,
  output logic              txn_ready,
  input  logic [3:0]        txn_cmd,
  input  logic [DATA_W-1:0] txn_op1,
  input  logic [DATA_W-1:0] txn_op2,
  output logic [3:0]        req_cmd_out,
  output logic [DATA_W-1:0] req_data_out,
  output logic [1:0]        req_tag_out,
  input  logic [1:0]        in_resp,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_tag,
  output logic              rsp_valid,
  output logic [1:0]        rsp_tag,
  output logic [3:0]        rsp_cmd,
  output logic [1:0]        rsp_status,
  output logic [DATA_W-1:0] rsp_data,
  output logic [2:0]        outstanding,
  output logic              err_spurious
);
  typedef enum logic [1:0] {IDLE, OP1, OP2} state_t;

  typedef struct packed {
    logic              valid;
    logic [1:0]        tag;
    logic [3:0]        cmd;
    logic [1:0]        status;
    logic [DATA_W-1:0] data;
  } rsp_t;

  state_t            state, state_n;
  logic [3:0]        busy, expired, alloc_vec, free_vec;
  logic [3:0][3:0]   slot_cmd;
  logic              free_found, accept, issue;
  logic [1:0]        free_tag, to_tag;
  logic              resp_ok, rsp_hit, spur, to_fire;
  logic [3:0]        cmd_n;
  logic [1:0]        tag_n;
  logic [DATA_W-1:0] data_n, op2_q;
  logic [2:0]        out_cnt;
  rsp_t              rsp_n, rsp_q;

  // Slots at or above MAX_OUT are tied off and never allocatable.
  for (genvar i = 0; i < 4; i++) begin : g_slot
    if (i < MAX_OUT) begin : g_used
      calc2_req_slot #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_slot (
        .c_clk   (c_clk),
        .reset   (reset),
        .alloc   (alloc_vec[i]),
        .free    (free_vec[i]),
        .cmd_in  (txn_cmd),
        .busy    (busy[i]),
        .cmd     (slot_cmd[i]),
        .expired (expired[i])
      );
    end else begin : g_unused
      assign busy[i]     = 1'b0;
      assign slot_cmd[i] = '0;
      assign expired[i]  = 1'b0;
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_tag   = '0;
    to_tag     = '0;
    out_cnt    = '0;
    for (int i = 3; i >= 0; i--) begin
      if (i < MAX_OUT && !busy[i]) begin
        free_found = 1'b1;
        free_tag   = 2'(i);
      end
      if (expired[i]) to_tag = 2'(i);
    end
    for (int i = 0; i < 4; i++) out_cnt = out_cnt + 3'(busy[i]);
  end

  // Ready looks only at registered state, so a tag freed this cycle is offered next cycle.
  assign txn_ready = !reset && (state != OP1) && free_found;
  assign accept    = txn_valid && txn_ready;
  assign issue     = accept && (txn_cmd != 4'd0);

  assign resp_ok = (in_resp == 2'b01) || (in_resp == 2'b10);
  assign rsp_hit = resp_ok && busy[in_tag];
  assign spur    = (in_resp != 2'b00) && !rsp_hit;
  // A real response owns the result port; a pending expiry waits for a free cycle.
  assign to_fire = !rsp_hit && (|expired);

  always_comb begin
    alloc_vec = '0;
    free_vec  = '0;
    if (issue)   alloc_vec[free_tag] = 1'b1;
    if (rsp_hit) free_vec[in_tag]    = 1'b1;
    if (to_fire) free_vec[to_tag]    = 1'b1;
  end

  always_comb begin
    state_n = state;
    cmd_n   = '0;
    tag_n   = '0;
    data_n  = '0;
    case (state)
      IDLE, OP2: begin
        state_n = IDLE;
        if (issue) begin
          state_n = OP1;
          cmd_n   = txn_cmd;
          tag_n   = free_tag;
          data_n  = txn_op1;
        end
      end
      OP1: begin
        state_n = OP2;
        tag_n   = req_tag_out;
        data_n  = op2_q;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rsp_n = '0;
    if (rsp_hit) begin
      rsp_n.valid  = 1'b1;
      rsp_n.tag    = in_tag;
      rsp_n.cmd    = slot_cmd[in_tag];
      rsp_n.status = in_resp;
      rsp_n.data   = (in_resp == 2'b01) ? in_data : '0;
    end else if (to_fire) begin
      rsp_n.valid  = 1'b1;
      rsp_n.tag    = to_tag;
      rsp_n.cmd    = slot_cmd[to_tag];
      rsp_n.status = 2'b11;
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state        <= IDLE;
      req_cmd_out  <= '0;
      req_tag_out  <= '0;
      req_data_out <= '0;
      op2_q        <= '0;
      rsp_q        <= '0;
      err_spurious <= 1'b0;
    end else begin
      state        <= state_n;
      req_cmd_out  <= cmd_n;
      req_tag_out  <= tag_n;
      req_data_out <= data_n;
      if (issue) op2_q <= txn_op2;
      rsp_q        <= rsp_n;
      err_spurious <= spur;
    end
  end

  assign rsp_valid   = rsp_q.valid;
  assign rsp_tag     = rsp_q.tag;
  assign rsp_cmd     = rsp_q.cmd;
  assign rsp_status  = rsp_q.status;
  assign rsp_data    = rsp_q.data;
  assign outstanding = out_cnt;
endmodule
